// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - sequential instruction prefetch into a small FIFO with redirect, drain and error halt
module ifu_prefetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h80000000,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,

    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,

    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    input  logic            mem_rsp_err,

    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [XLEN-1:0] buf_pc_q   [DEPTH];
    logic [XLEN-1:0] buf_data_q [DEPTH];
    logic            buf_err_q  [DEPTH];

    logic            has_head;
    logic            push;
    logic            pop;
    logic [CW-1:0]   count_after;
    logic [XLEN-1:0] redirect_target;
    logic            unused_redirect_low;

    assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_low = ^redirect_pc[1:0];

    // Outputs are gated by rst so nothing leaks out while reset is held.
    assign has_head      = rst && (count_q != '0);
    assign inst_valid    = has_head && !redirect_valid;
    assign inst_data     = has_head ? buf_data_q[rd_ptr_q] : '0;
    assign inst_pc       = has_head ? buf_pc_q[rd_ptr_q]   : '0;
    assign inst_err      = has_head ? buf_err_q[rd_ptr_q]  : 1'b0;

    assign mem_req_valid = rst && (state_q == S_REQ);
    assign mem_req_addr  = pc_q;

    assign pop         = inst_valid && inst_ready;
    assign push        = rst && !redirect_valid && (state_q == S_WAIT) && mem_rsp_valid;
    assign count_after = count_q + CW'(push) - CW'(pop);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (redirect_valid) begin
            pc_d     = redirect_target;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            // A request still owed a response must have that response swallowed.
            case (state_q)
                S_REQ:   state_d = mem_req_ready ? S_DRAIN : S_REQ;
                S_WAIT,
                S_DRAIN: state_d = mem_rsp_valid ? S_REQ : S_DRAIN;
                default: state_d = S_REQ;
            endcase
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_after;

            case (state_q)
                S_IDLE: begin
                    if (count_q < CW'(DEPTH)) begin
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        if (mem_rsp_err) begin
                            state_d = S_HALT;
                        end else begin
                            pc_d    = pc_q + XLEN'(4);
                            state_d = (count_after < CW'(DEPTH)) ? S_REQ : S_IDLE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (mem_rsp_valid) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_HALT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observable when counted.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_q[wr_ptr_q]   <= pc_q;
            buf_data_q[wr_ptr_q] <= mem_rsp_data;
            buf_err_q[wr_ptr_q]  <= mem_rsp_err;
        end
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - bench for ifu_prefetch: queue-based reference model, directed scenarios and random traffic
module tb_ifu_prefetch;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h80000000;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_err;

    ifu_prefetch #(.XLEN(XLEN), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_err   (mem_rsp_err),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .inst_err      (inst_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        err;
    } ent_t;

    // Reference model: buffered entries, fetch address, and whether a request is owed a response.
    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_out;
    bit          m_disc;
    bit          m_halt;
    bit          m_block;

    int n_tests = 0;
    int n_fail  = 0;
    bit armed   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_req_valid();
        return rst && !m_out && !m_halt && !m_block;
    endfunction

    function automatic bit exp_inst_valid();
        return rst && !redirect_valid && (mq.size() != 0);
    endfunction

    task automatic model_step();
        bit   ev;
        bit   ivld;
        int   sz0;
        ent_t e;
        ev   = exp_req_valid();
        ivld = exp_inst_valid();
        sz0  = mq.size();
        if (!rst) begin
            mq.delete();
            m_pc = RPC; m_out = 0; m_disc = 0; m_halt = 0; m_block = 0;
        end else if (redirect_valid) begin
            mq.delete();
            m_pc    = {redirect_pc[31:2], 2'b00};
            m_halt  = 0;
            m_block = 0;
            if (ev && mem_req_ready) begin
                m_out = 1; m_disc = 1;
            end else if (m_out && mem_rsp_valid) begin
                m_out = 0; m_disc = 0;
            end else if (m_out) begin
                m_disc = 1;
            end
        end else begin
            if (ivld && inst_ready) void'(mq.pop_front());
            if (ev && mem_req_ready) begin
                m_out = 1;
            end else if (m_out && mem_rsp_valid) begin
                m_out = 0;
                if (m_disc) begin
                    m_disc = 0;
                end else begin
                    e.pc = m_pc; e.data = mem_rsp_data; e.err = mem_rsp_err;
                    mq.push_back(e);
                    if (mem_rsp_err) m_halt = 1;
                    else begin
                        m_pc    = m_pc + 32'd4;
                        m_block = (mq.size() >= DEPTH);
                    end
                end
            end else if (m_block && sz0 < DEPTH) begin
                m_block = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            check_b("mem_req_valid", mem_req_valid, exp_req_valid());
            if (exp_req_valid()) check32("mem_req_addr", mem_req_addr, m_pc);
            check_b("inst_valid", inst_valid, exp_inst_valid());
            if (exp_inst_valid()) begin
                check32("inst_pc", inst_pc, mq[0].pc);
                check32("inst_data", inst_data, mq[0].data);
                check_b("inst_err", inst_err, mq[0].err);
            end
            if (!rst) begin
                check32("rst_inst_data", inst_data, 32'h0);
                check32("rst_inst_pc", inst_pc, 32'h0);
                check_b("rst_inst_err", inst_err, 1'b0);
            end
        end
    end

    task automatic drive(input bit rdy, input bit rv, input logic [31:0] rd, input bit re,
                         input bit rdir, input logic [31:0] rpc, input bit ir);
        mem_req_ready  = rdy;
        mem_rsp_valid  = rv;
        mem_rsp_data   = rd;
        mem_rsp_err    = re;
        redirect_valid = rdir;
        redirect_pc    = rpc;
        inst_ready     = ir;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        logic [31:0] acc[$];
        logic [31:0] pops[$];
        ent_t        popped[$];
        int          t_acc0;
        int          t_iv0;
        int          nacc;

        rst = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0);
        tick();
        armed = 1;
        repeat (2) begin
            #2;
            check_b("reset_req_valid", mem_req_valid, 1'b0);
            check_b("reset_inst_valid", inst_valid, 1'b0);
            tick();
        end

        // Streaming from reset with one-cycle response latency
        rst = 1'b1;
        drive(1, 1, $urandom, 0, 0, 32'h0, 1);
        t_acc0 = -1; t_iv0 = -1;
        for (int c = 0; c < 14; c++) begin
            mem_rsp_data = $urandom;
            #2;
            if (mem_req_valid && mem_req_ready) begin
                acc.push_back(mem_req_addr);
                if (t_acc0 < 0) t_acc0 = c;
            end
            if (inst_valid) begin
                if (t_iv0 < 0) t_iv0 = c;
                pops.push_back(inst_pc);
            end
            tick();
        end
        check32("first_req_cycle", t_acc0, 32'd0);
        check32("stream_req_count", acc.size(), 32'd7);
        check32("req_addr0", acc[0], 32'h80000000);
        check32("req_addr1", acc[1], 32'h80000004);
        check32("req_addr2", acc[2], 32'h80000008);
        check32("first_inst_latency", t_iv0 - t_acc0, 32'd2);
        check32("stream_pc0", pops[0], 32'h80000000);
        check32("stream_pc1", pops[1], 32'h80000004);

        // Stalled decode: fill exactly DEPTH entries, then one pop buys one request
        drive(0, 1, $urandom, 0, 1, 32'h80000100, 0);
        #2;
        check_b("redirect_inst_valid", inst_valid, 1'b0);
        tick();
        redirect_valid = 0;
        mem_req_ready  = 1;
        nacc = 0;
        for (int c = 0; c < 20; c++) begin
            mem_rsp_data = $urandom;
            #2;
            if (mem_req_valid && mem_req_ready) nacc++;
            tick();
        end
        check32("full_fetch_count", nacc, 32'd4);
        inst_ready = 1;
        #2;
        check_b("full_no_req", mem_req_valid, 1'b0);
        check_b("full_inst_valid", inst_valid, 1'b1);
        check32("full_head_pc", inst_pc, 32'h80000100);
        tick();
        inst_ready = 0;
        nacc = 0;
        for (int c = 0; c < 10; c++) begin
            #2;
            if (mem_req_valid && mem_req_ready) nacc++;
            tick();
        end
        check32("refill_after_pop", nacc, 32'd1);

        // Drain from full with responses landing on pop cycles
        inst_ready = 1;
        pops.delete();
        for (int c = 0; c < 14; c++) begin
            mem_rsp_data = $urandom;
            #2;
            if (inst_valid && inst_ready) pops.push_back(inst_pc);
            tick();
        end
        check32("order_pc0", pops[0], 32'h80000104);
        check32("order_pc1", pops[1], 32'h80000108);
        check32("order_pc3", pops[3], 32'h80000110);
        check32("order_pc4", pops[4], 32'h80000114);

        // Redirect while waiting, then a late response that must be dropped
        drive(1, 0, 32'h0, 0, 0, 32'h0, 1);
        repeat (4) begin #2; tick(); end
        drive(0, 0, 32'h0, 0, 1, 32'h80001002, 1);
        #2;
        check_b("wait_no_req", mem_req_valid, 1'b0);
        check_b("redir_wait_inst_valid", inst_valid, 1'b0);
        tick();
        drive(0, 1, 32'hDEADBEEF, 0, 0, 32'h0, 1);
        #2;
        check_b("drain_no_req", mem_req_valid, 1'b0);
        tick();
        drive(0, 0, 32'h0, 0, 0, 32'h0, 1);
        #2;
        check_b("post_drain_req", mem_req_valid, 1'b1);
        check32("post_drain_addr", mem_req_addr, 32'h80001000);
        check_b("post_drain_empty", inst_valid, 1'b0);
        tick();
        mem_req_ready = 1;
        #2; tick();
        drive(0, 1, 32'h12345678, 0, 0, 32'h0, 0);
        #2; tick();
        mem_rsp_valid = 0;
        #2;
        check32("post_drain_inst_pc", inst_pc, 32'h80001000);
        check32("post_drain_inst_data", inst_data, 32'h12345678);
        tick();

        // Error response halts fetching
        drive(0, 1, 32'h0, 0, 1, 32'h80000000, 1);
        #2; tick();
        drive(1, 1, 32'h0, 0, 0, 32'h0, 1);
        nacc = 0;
        for (int c = 0; c < 16; c++) begin
            mem_rsp_data = $urandom;
            mem_rsp_err  = m_out && (m_pc == 32'h80000008);
            #2;
            if (m_halt && mem_req_valid && mem_req_ready) nacc++;
            if (inst_valid && inst_ready) popped.push_back({inst_pc, inst_data, inst_err});
            tick();
        end
        check32("err_pop_count", popped.size(), 32'd3);
        check_b("err_first_ok", popped[0].err, 1'b0);
        check32("err_entry_pc", popped[2].pc, 32'h80000008);
        check_b("err_entry_flag", popped[2].err, 1'b1);
        check32("halt_req_count", nacc, 32'd0);
        mem_rsp_err = 0;

        // Address wrap at the top of the space; low redirect bits are cleared
        drive(0, 1, 32'h0, 0, 1, 32'hFFFFFFFE, 1);
        #2; tick();
        drive(1, 1, 32'h0, 0, 0, 32'h0, 1);
        acc.delete();
        for (int c = 0; c < 6; c++) begin
            mem_rsp_data = $urandom;
            #2;
            if (mem_req_valid && mem_req_ready) acc.push_back(mem_req_addr);
            tick();
        end
        check32("wrap_addr0", acc[0], 32'hFFFFFFFC);
        check32("wrap_addr1", acc[1], 32'h00000000);
        check32("wrap_addr2", acc[2], 32'h00000004);

        // Reset in the middle of an outstanding request
        drive(1, 0, 32'h0, 0, 0, 32'h0, 0);
        repeat (2) begin #2; tick(); end
        rst = 0;
        drive(0, 1, 32'hCAFEF00D, 0, 0, 32'h0, 0);
        repeat (2) begin #2; tick(); end
        rst = 1;
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0);
        #2;
        check_b("rerst_req_valid", mem_req_valid, 1'b1);
        check32("rerst_req_addr", mem_req_addr, RPC);
        check_b("rerst_inst_valid", inst_valid, 1'b0);
        tick();
        #2;
        check_b("rerst_no_push", inst_valid, 1'b0);
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst            = ($urandom_range(0, 299) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                                         : $urandom;
            mem_req_ready  = ($urandom_range(0, 9) < 6);
            mem_rsp_valid  = ($urandom_range(0, 9) < 4);
            mem_rsp_data   = $urandom;
            mem_rsp_err    = ($urandom_range(0, 15) == 0);
            inst_ready     = ($urandom_range(0, 1) == 1);
            #2;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
